// File: rtl/pf_sched_pkg.sv
// Shared types and width helpers for the pf_sched parity-flag scheduler.
package pf_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // $clog2 with a floor of 1, so a counter or index always has at least one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pf_sched_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N_REQ.
module rr_pick
    import pf_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]             req_i,
    input  logic [clog2_min1(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]             gnt_o,
    output logic [clog2_min1(N_REQ)-1:0] idx_o,
    output logic                         any_o
);

    localparam int IW = clog2_min1(N_REQ);

    logic [IW-1:0] pos;

    // Walk the rotated request order from ptr_i and keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = IW'((int'(ptr_i) + k) % N_REQ);
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/pf_sched.sv
// Round-robin scheduler sharing one serial parity/ones-count evaluator among
// N_REQ requesters. A job shifts the winner's operand one bit per cycle, then
// publishes ones count and PF/NF with a one-cycle ack to the winner.
// Valid/ready: a requester holds i_req (with stable i_data) until it sees its
// o_ack bit; dropping i_req mid-job aborts the job with no ack and no result.
module pf_sched
    import pf_sched_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int N_REQ = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rsn,
    input  logic [N_REQ-1:0]             i_req,
    input  logic [N_REQ*BITS-1:0]        i_data,
    output logic [N_REQ-1:0]             o_gnt,
    output logic [N_REQ-1:0]             o_ack,
    output logic                         o_busy,
    output logic                         o_valid,
    output logic [clog2_min1(N_REQ)-1:0] o_id,
    output logic [$clog2(BITS+1)-1:0]    o_ones,
    output logic                         o_pf,
    output logic                         o_nf,
    output logic [1:0]                   o_state
);

    localparam int IW = clog2_min1(N_REQ);
    localparam int CW = clog2_min1(BITS);
    localparam int OW = $clog2(BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     id_q, id_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [BITS-1:0]   sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OW-1:0]     acc_q, acc_d;
    logic              par_q, par_d;
    logic [OW-1:0]     ones_q, ones_d;
    logic              pf_q, pf_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [BITS-1:0]   win_data;
    logic [OW-1:0]     acc_nxt;
    logic              par_nxt;
    logic              req_held;
    logic [IW-1:0]     ptr_inc;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Operand of the round-robin winner, selected from the flat data bus.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) win_data = i_data[i*BITS +: BITS];
        end
    end

    assign acc_nxt  = acc_q + OW'(sh_q[0]);
    assign par_nxt  = par_q ^ sh_q[0];
    assign req_held = |(i_req & gnt_q);
    assign ptr_inc  = IW'((int'(id_q) + 1) % N_REQ);

    // Next-state and datapath control; every register holds unless changed.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        par_d   = par_q;
        ones_d  = ones_q;
        pf_d    = pf_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = SHIFT;
                    gnt_d   = pick_gnt;
                    id_d    = pick_idx;
                    sh_d    = win_data;
                    cnt_d   = '0;
                    acc_d   = '0;
                    par_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (!req_held) begin
                    // Abort: the pointer still moves past the abandoned requester.
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_inc;
                end else begin
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    acc_d = acc_nxt;
                    par_d = par_nxt;
                    if (cnt_q == CNT_LAST) begin
                        // Results include the last bit shifted on this edge.
                        state_d = DONE;
                        ones_d  = acc_nxt;
                        pf_d    = par_nxt;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_inc;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight job.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            par_q   <= 1'b0;
            ones_q  <= '0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            par_q   <= par_d;
            ones_q  <= ones_d;
            pf_q    <= pf_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_ack   = (state_q == DONE) ? gnt_q : '0;
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q != IDLE);
    assign o_id    = id_q;
    assign o_ones  = ones_q;
    assign o_pf    = pf_q;
    assign o_nf    = ~pf_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_pf_sched.sv
// Testbench for pf_sched: table-driven single jobs, hand-written corner
// sequences (wrap, round robin, abort, reset mid-job, 8-bit boundaries) and
// randomized multi-requester traffic checked against a round-robin model.
module tb_pf_sched;

    localparam int BITS  = 4;
    localparam int N     = 4;
    localparam int BITS8 = 8;
    localparam int N8    = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rsn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (BITS=4, N_REQ=4) ----------------
    logic [N-1:0]      req;
    logic [N*BITS-1:0] data;
    logic [N-1:0]      gnt, ack;
    logic              busy, valid, pf, nf;
    logic [1:0]        id;
    logic [2:0]        ones;
    logic [1:0]        st;

    pf_sched #(.BITS(BITS), .N_REQ(N)) dut (
        .i_clk(clk), .i_rsn(rsn), .i_req(req), .i_data(data),
        .o_gnt(gnt), .o_ack(ack), .o_busy(busy), .o_valid(valid),
        .o_id(id), .o_ones(ones), .o_pf(pf), .o_nf(nf), .o_state(st)
    );

    // ---------------- DUT (BITS=8, N_REQ=2) ----------------
    logic [N8-1:0]       req8;
    logic [N8*BITS8-1:0] data8;
    logic [N8-1:0]       gnt8, ack8;
    logic                busy8, valid8, pf8, nf8;
    logic [0:0]          id8;
    logic [3:0]          ones8;
    logic [1:0]          st8;

    pf_sched #(.BITS(BITS8), .N_REQ(N8)) dut8 (
        .i_clk(clk), .i_rsn(rsn), .i_req(req8), .i_data(data8),
        .o_gnt(gnt8), .o_ack(ack8), .o_busy(busy8), .o_valid(valid8),
        .o_id(id8), .o_ones(ones8), .o_pf(pf8), .o_nf(nf8), .o_state(st8)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = 0;
    logic [15:0] exp_q[$];   // {winner id, ones count} per expected completion

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // Round-robin reference: first set request at or after p, wrapping.
    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (((r >> j) & 4'b1) != 4'b0) return j;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    // Serve one job on dut: pop the expected {id, ones}, follow the job from
    // grant to ack, then drop the winner's request unless keep is set.
    task automatic serve(input bit keep, input string tag);
        logic [15:0] e;
        int eid, eones, n;
        bit seen;
        e     = exp_q.pop_front();
        eid   = int'(e[15:8]);
        eones = int'(e[7:0]);
        seen  = 1'b0;
        for (int t = 0; t < 3*BITS + 8 && !seen; t++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        check({tag, " grant seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, " gnt"}, 32'(gnt), 32'(4'b1 << eid));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " id"}, 32'(id), 32'(eid));
        n = 1;
        while (!valid && n < 2*BITS + 4) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(BITS + 1));
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " ack"}, 32'(ack), 32'(4'b1 << eid));
        check({tag, " gnt at done"}, 32'(gnt), 32'(4'b1 << eid));
        check({tag, " ones"}, 32'(ones), 32'(eones));
        check({tag, " pf"}, 32'(pf), 32'(eones % 2));
        check({tag, " nf"}, 32'(nf), 32'(1 - (eones % 2)));
        @(posedge clk); #1;
        if (!keep) req = req & ~(4'b1 << eid);
        m_ptr = (eid + 1) % N;
        @(negedge clk);
        check({tag, " idle after done"}, {29'd0, valid, busy, |ack}, 32'd0);
    endtask

    // Serve one job on dut8; call right after driving at posedge+1 while idle.
    task automatic serve8(input int eid, input int eones, input string tag);
        int n;
        n = 0;
        while (!valid8 && n < 2*BITS8 + 6) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(BITS8 + 2));
        check({tag, " ack"}, 32'(ack8), 32'(2'b1 << eid));
        check({tag, " id"}, 32'(id8), 32'(eid));
        check({tag, " ones"}, 32'(ones8), 32'(eones));
        check({tag, " pf"}, 32'(pf8), 32'(eones % 2));
        check({tag, " nf"}, 32'(nf8), 32'(1 - (eones % 2)));
        @(posedge clk); #1;
        req8 = '0;
    endtask

    typedef struct {
        logic [N-1:0]      req;
        logic [N*BITS-1:0] data;
        int                exp_id;
        int                exp_ones;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit seen;
        bit keep;

        // Single jobs applied in sequence from reset; ids follow the pointer.
        tbl[0] = '{4'b0010, 16'h00B0, 1, 3};
        tbl[1] = '{4'b0001, 16'h000F, 0, 4};
        tbl[2] = '{4'b1001, 16'h8001, 3, 1};
        tbl[3] = '{4'b1001, 16'h6005, 0, 2};   // last served 3, wraps to 0
        tbl[4] = '{4'b1100, 16'h0E00, 2, 3};
        tbl[5] = '{4'b0110, 16'h0D90, 1, 2};
        tbl[6] = '{4'b1111, 16'h0B00, 2, 3};

        rsn = 1'b0; req = '0; data = '0; req8 = '0; data8 = '0;
        @(posedge clk); #1;
        check("reset state", {30'd0, st}, 32'd0);
        check("reset gnt/ack", {24'd0, gnt, ack}, 32'd0);
        check("reset busy/valid", {30'd0, busy, valid}, 32'd0);
        check("reset id", 32'(id), 32'd0);
        check("reset ones", 32'(ones), 32'd0);
        check("reset pf/nf", {30'd0, pf, nf}, 32'd1);
        check("reset8 ones/pf/nf", {26'd0, ones8, pf8, nf8}, 32'd1);
        @(negedge clk);
        rsn = 1'b1;

        // ---- table-driven single jobs ----
        for (int v = 0; v < 7; v++) begin
            data = tbl[v].data;
            req  = tbl[v].req;
            exp_q.push_back({8'(tbl[v].exp_id), 8'(tbl[v].exp_ones)});
            serve(1'b0, $sformatf("vec%0d", v));
            req = '0;
        end

        // ---- reset in the middle of a job ----
        data = 16'h00B0;
        req  = 4'b0010;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        check("rst-mid grant", 32'(gnt), 32'h2);
        @(posedge clk); #2;
        rsn = 1'b0;
        #1;
        check("rst-mid gnt/ack", {24'd0, gnt, ack}, 32'd0);
        check("rst-mid busy/valid", {30'd0, busy, valid}, 32'd0);
        check("rst-mid id", 32'(id), 32'd0);
        check("rst-mid ones", 32'(ones), 32'd0);
        check("rst-mid pf/nf", {30'd0, pf, nf}, 32'd1);
        req   = 4'b1111;
        data  = 16'h7310;
        m_ptr = 0;
        @(negedge clk);
        rsn = 1'b1;

        // ---- round robin with all requesters held ----
        exp_q.push_back({8'd0, 8'd0});
        exp_q.push_back({8'd1, 8'd1});
        exp_q.push_back({8'd2, 8'd2});
        exp_q.push_back({8'd3, 8'd3});
        exp_q.push_back({8'd0, 8'd0});
        for (int k = 0; k < 5; k++) serve(1'b1, $sformatf("rr%0d", k));
        req = '0;

        // ---- abort: leave a known result, then abandon a job ----
        data = 16'h0070;
        req  = 4'b0010;
        exp_q.push_back({8'd1, 8'd3});
        serve(1'b0, "pre-abort");
        req  = '0;
        data = 16'h0300;
        req  = 4'b0100;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        check("abort grant", 32'(gnt), 32'h4);
        @(posedge clk);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        check("abort still busy", {30'd0, busy, valid}, 32'd2);
        @(negedge clk);
        check("abort idle", {28'd0, busy, valid, |gnt, |ack}, 32'd0);
        check("abort ones kept", 32'(ones), 32'd3);
        check("abort pf/nf kept", {30'd0, pf, nf}, 32'd2);
        m_ptr = 3;
        data = 16'hE321;
        req  = 4'b1111;
        exp_q.push_back({8'd3, 8'd3});
        serve(1'b0, "post-abort");
        req = '0;

        // ---- randomized traffic against the round-robin model ----
        for (int j = 0; j < N; j++) data[j*BITS +: BITS] = 4'($urandom_range(0, 15));
        req = 4'($urandom_range(1, 15));
        for (int r = 0; r < 30; r++) begin
            int w;
            w = rr(req, m_ptr);
            exp_q.push_back({8'(w), 8'($countones(data[w*BITS +: BITS]))});
            keep = ($urandom_range(0, 3) == 0);
            serve(keep, $sformatf("rand%0d", r));
            for (int j = 0; j < N; j++) begin
                if (((req >> j) & 4'b1) == 4'b0 && $urandom_range(0, 2) == 0) begin
                    data[j*BITS +: BITS] = 4'($urandom_range(0, 15));
                    req = req | 4'(1 << j);
                end
            end
            if (req == '0) begin
                int j;
                j = $urandom_range(0, N - 1);
                data[j*BITS +: BITS] = 4'($urandom_range(0, 15));
                req = 4'(1 << j);
            end
        end
        req = '0;

        // ---- 8-bit boundaries: all ones, and MSB only ----
        @(posedge clk); #1;
        data8 = 16'h00FF;
        req8  = 2'b01;
        serve8(0, 8, "w8 ff");
        @(posedge clk); #1;
        data8 = 16'h8000;
        req8  = 2'b10;
        serve8(1, 1, "w8 80");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
